// File: rtl/float_div_seq.sv
// Multi-cycle restoring floating-point divider: one quotient bit per clock,
// round-to-nearest-even, with divide-by-zero, overflow and underflow flags.
module float_div_seq #(
  parameter int NM = 23,
  parameter int NE = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [NE+NM:0] a,
  input  logic [NE+NM:0] b,
  output logic           busy,
  output logic           done,
  output logic [NE+NM:0] result,
  output logic           dz,
  output logic           ovf,
  output logic           unf
);

  localparam int CW = $clog2(NM + 4);
  localparam logic [NE+1:0]        BIAS = (NE+2)'((1 << (NE - 1)) - 1);
  localparam logic signed [NE+1:0] EMAX = (NE+2)'((1 << NE) - 1);
  localparam logic [CW-1:0]        LAST = CW'(NM + 2);

  typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

  state_t state, state_next;

  logic [NM+1:0]        r;
  logic [NM:0]          d;
  logic [NM+2:0]        q;
  logic [CW-1:0]        cnt;
  logic signed [NE+1:0] x;
  logic                 sign;
  logic                 a_zero;
  logic                 b_zero;

  logic                 ge;
  logic [NM+1:0]        r_sub;

  logic [NM-1:0]        mant;
  logic                 g;
  logic                 st;
  logic signed [NE+1:0] xa;
  logic signed [NE+1:0] xr;
  logic [NM:0]          mant_inc;
  logic [NE+NM:0]       res_c;
  logic                 dz_c;
  logic                 ovf_c;
  logic                 unf_c;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Restoring step; r < 2d keeps r_sub below d, so the left shift never drops a bit.
  assign ge    = (r >= {1'b0, d});
  assign r_sub = ge ? (r - {1'b0, d}) : r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      d      <= '0;
      q      <= '0;
      cnt    <= '0;
      x      <= '0;
      sign   <= 1'b0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r      <= {1'b0, 1'b1, a[NM-1:0]};
          d      <= {1'b1, b[NM-1:0]};
          q      <= '0;
          cnt    <= '0;
          x      <= $signed({2'b00, a[NE+NM-1:NM]} - {2'b00, b[NE+NM-1:NM]} + BIAS);
          sign   <= a[NE+NM] ^ b[NE+NM];
          a_zero <= (a[NE+NM-1:NM] == '0);
          b_zero <= (b[NE+NM-1:NM] == '0);
        end
        CALC: begin
          r   <= {r_sub[NM:0], 1'b0};
          q   <= {q[NM+1:0], ge};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Normalise, round to nearest even, then apply range limits and special operands.
  always_comb begin
    res_c = '0;
    dz_c  = 1'b0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (q[NM+2]) begin
      mant = q[NM+1:2];
      g    = q[1];
      st   = q[0] | (r != '0);
      xa   = x;
    end else begin
      mant = q[NM:1];
      g    = q[0];
      st   = (r != '0);
      xa   = x - (NE+2)'(1);
    end
    mant_inc = {1'b0, mant} + {{NM{1'b0}}, g & (st | mant[0])};
    xr       = mant_inc[NM] ? (xa + (NE+2)'(1)) : xa;
    if (b_zero) begin
      res_c = {sign, {NE{1'b1}}, {NM{1'b0}}};
      dz_c  = 1'b1;
    end else if (a_zero) begin
      res_c = {sign, {(NE+NM){1'b0}}};
    end else if (xr >= EMAX) begin
      res_c = {sign, {(NE-1){1'b1}}, 1'b0, {NM{1'b1}}};
      ovf_c = 1'b1;
    end else if (xr[NE+1] || (xr == '0)) begin
      res_c = {sign, {(NE+NM){1'b0}}};
      unf_c = 1'b1;
    end else begin
      res_c = {sign, xr[NE-1:0], mant_inc[NM-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      done <= (state == ROUND);
      if (state == ROUND) begin
        result <= res_c;
        dz     <= dz_c;
        ovf    <= ovf_c;
        unf    <= unf_c;
      end
    end
  end

endmodule
